// File: rtl/itcm_if.sv
// Fetch-side and load/store-side command/response bundle for the ITCM controller.
// The controller is the slave; the IFU/LSU side is the master.
interface itcm_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // IFU fetch port
    logic          ifu_cmd_valid;
    logic          ifu_cmd_ready;
    logic [AW-1:0] ifu_cmd_addr;
    logic          ifu_flush;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_ready;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          ifu_rsp_err;

    // LSU read/write port
    logic            lsu_cmd_valid;
    logic            lsu_cmd_ready;
    logic [AW-1:0]   lsu_cmd_addr;
    logic            lsu_cmd_read;
    logic [DW-1:0]   lsu_cmd_wdata;
    logic [DW/8-1:0] lsu_cmd_wmask;
    logic            lsu_rsp_valid;
    logic            lsu_rsp_ready;
    logic [DW-1:0]   lsu_rsp_rdata;
    logic            lsu_rsp_err;

    modport master (
        output ifu_cmd_valid, ifu_cmd_addr, ifu_flush, ifu_rsp_ready,
        input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
        output lsu_cmd_valid, lsu_cmd_addr, lsu_cmd_read, lsu_cmd_wdata, lsu_cmd_wmask,
        output lsu_rsp_ready,
        input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err
    );

    modport slave (
        input  ifu_cmd_valid, ifu_cmd_addr, ifu_flush, ifu_rsp_ready,
        output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
        input  lsu_cmd_valid, lsu_cmd_addr, lsu_cmd_read, lsu_cmd_wdata, lsu_cmd_wmask,
        input  lsu_rsp_ready,
        output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err
    );
endinterface

// File: rtl/itcm_ctrl.sv
// Single-port ITCM controller: round-robin arbitration of IFU fetches and LSU
// read/write accesses onto one synchronous word array, with a one-entry
// response register per port.
module itcm_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input logic   clk,
    input logic   rst_n,
    itcm_if.slave bus
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned NumBytes = DW / 8;

    // rr_last encoding: which port received the most recent grant
    localparam logic PortIfu = 1'b0;
    localparam logic PortLsu = 1'b1;

    logic [DW-1:0] mem [Depth];

    logic                  rr_last_q;
    logic                  ifu_rsp_valid_q, lsu_rsp_valid_q;
    logic [DW-1:0]         ifu_rsp_rdata_q, lsu_rsp_rdata_q;
    logic                  ifu_rsp_err_q, lsu_rsp_err_q;

    logic [DEPTH_LOG2-1:0] ifu_idx, lsu_idx, acc_idx;
    logic                  ifu_oor, lsu_oor;
    logic                  slot_free_ifu, slot_free_lsu;
    logic                  req_ifu, req_lsu;
    logic                  ifu_ready, lsu_ready;
    logic                  grant_ifu, grant_lsu;
    logic                  mem_we;
    logic [DW-1:0]         mem_rdata;

    assign ifu_idx = bus.ifu_cmd_addr[DEPTH_LOG2+1:2];
    assign lsu_idx = bus.lsu_cmd_addr[DEPTH_LOG2+1:2];
    assign ifu_oor = |bus.ifu_cmd_addr[AW-1:DEPTH_LOG2+2];
    assign lsu_oor = |bus.lsu_cmd_addr[AW-1:DEPTH_LOG2+2];

    // Arbitration; ready is formed without the port's own valid, only the other's request
    always_comb begin
        slot_free_ifu = ~ifu_rsp_valid_q | bus.ifu_rsp_ready | bus.ifu_flush;
        slot_free_lsu = ~lsu_rsp_valid_q | bus.lsu_rsp_ready;
        req_ifu       = bus.ifu_cmd_valid & slot_free_ifu;
        req_lsu       = bus.lsu_cmd_valid & slot_free_lsu;
        ifu_ready     = rst_n & slot_free_ifu & ~(req_lsu & (rr_last_q == PortIfu));
        lsu_ready     = rst_n & slot_free_lsu & ~(req_ifu & (rr_last_q == PortLsu));
        grant_ifu     = bus.ifu_cmd_valid & ifu_ready;
        grant_lsu     = bus.lsu_cmd_valid & lsu_ready;
        acc_idx       = grant_lsu ? lsu_idx : ifu_idx;
        mem_we        = grant_lsu & ~bus.lsu_cmd_read & ~lsu_oor;
    end

    assign mem_rdata = mem[acc_idx];

    assign bus.ifu_cmd_ready = ifu_ready;
    assign bus.lsu_cmd_ready = lsu_ready;
    assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
    assign bus.ifu_rsp_rdata = ifu_rsp_rdata_q;
    assign bus.ifu_rsp_err   = ifu_rsp_err_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.lsu_rsp_rdata = lsu_rsp_rdata_q;
    assign bus.lsu_rsp_err   = lsu_rsp_err_q;

    // Array write port: masked byte lanes, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (bus.lsu_cmd_wmask[b]) begin
                    mem[lsu_idx][8*b +: 8] <= bus.lsu_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    // Round-robin pointer follows every grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q <= PortIfu;
        end else if (grant_lsu) begin
            rr_last_q <= PortLsu;
        end else if (grant_ifu) begin
            rr_last_q <= PortIfu;
        end
    end

    // IFU response register: load on grant, drop on handshake or flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_rdata_q <= '0;
            ifu_rsp_err_q   <= 1'b0;
        end else if (grant_ifu) begin
            ifu_rsp_valid_q <= 1'b1;
            ifu_rsp_rdata_q <= ifu_oor ? '0 : mem_rdata;
            ifu_rsp_err_q   <= ifu_oor;
        end else if (bus.ifu_rsp_ready || bus.ifu_flush) begin
            ifu_rsp_valid_q <= 1'b0;
        end
    end

    // LSU response register: writes return zero data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_rdata_q <= '0;
            lsu_rsp_err_q   <= 1'b0;
        end else if (grant_lsu) begin
            lsu_rsp_valid_q <= 1'b1;
            lsu_rsp_rdata_q <= (lsu_oor || !bus.lsu_cmd_read) ? '0 : mem_rdata;
            lsu_rsp_err_q   <= lsu_oor;
        end else if (bus.lsu_rsp_ready) begin
            lsu_rsp_valid_q <= 1'b0;
        end
    end

    // Byte-offset bits are ignored by design
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.ifu_cmd_addr[1:0], bus.lsu_cmd_addr[1:0]};

endmodule

// File: tb/tb_itcm_ctrl.sv
// Directed, table-driven bench for itcm_ctrl.
module tb_itcm_ctrl;
    localparam int unsigned DEPTH_LOG2 = 14;
    localparam logic [31:0] OOR = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    itcm_if #(.AW(32), .DW(32)) bus ();

    itcm_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] ia;
        logic        fl;
        logic        irr;
        logic        lv;
        logic [31:0] la;
        logic        lr;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        lrr;
        logic        e_ir;
        logic        e_lr;
        logic        e_iv;
        logic [31:0] e_id;
        logic        e_ie;
        logic        e_lv;
        logic [31:0] e_ld;
        logic        e_le;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    function automatic vec_t mk(
        logic iv, logic [31:0] ia, logic fl, logic irr,
        logic lv, logic [31:0] la, logic lr, logic [31:0] wd, logic [3:0] wm, logic lrr,
        logic e_ir, logic e_lr,
        logic e_iv, logic [31:0] e_id, logic e_ie,
        logic e_lv, logic [31:0] e_ld, logic e_le);
        vec_t v;
        v = '{iv, ia, fl, irr, lv, la, lr, wd, wm, lrr,
              e_ir, e_lr, e_iv, e_id, e_ie, e_lv, e_ld, e_le};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.ifu_cmd_valid = v.iv;
        bus.ifu_cmd_addr  = v.ia;
        bus.ifu_flush     = v.fl;
        bus.ifu_rsp_ready = v.irr;
        bus.lsu_cmd_valid = v.lv;
        bus.lsu_cmd_addr  = v.la;
        bus.lsu_cmd_read  = v.lr;
        bus.lsu_cmd_wdata = v.wd;
        bus.lsu_cmd_wmask = v.wm;
        bus.lsu_rsp_ready = v.lrr;
    endtask

    initial begin
        drive('0);

        // Reset: two edges with rst_n low
        repeat (2) @(posedge clk);
        #1;
        chk("reset ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd0);
        chk("reset ifu_rsp_rdata", bus.ifu_rsp_rdata, 32'd0);
        chk("reset ifu_rsp_err",   32'(bus.ifu_rsp_err), 32'd0);
        chk("reset lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd0);
        chk("reset lsu_rsp_rdata", bus.lsu_rsp_rdata, 32'd0);
        chk("reset lsu_rsp_err",   32'(bus.lsu_rsp_err), 32'd0);
        rst_n = 1'b1;

        //         iv ia          fl irr  lv la          lr wd            wm    lrr
        //         ir lr  iv id           ie  lv ld           le
        // preload + first fetch
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h10, 0, 32'hDEADBEEF, 4'hF, 1,
                          0, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        vecs.push_back(mk(1, 32'h10, 0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 0,  1, 32'hDEADBEEF, 0,  0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h0,  0, 32'h11111111, 4'hF, 1,
                          0, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h4,  0, 32'h22222222, 4'hF, 1,
                          1, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h8,  0, 32'h33333333, 4'hF, 1,
                          1, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h20, 0, 32'h11223344, 4'hF, 1,
                          1, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h40, 0, 32'h40404040, 4'hF, 1,
                          1, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        // IFU streaming, one response per cycle
        vecs.push_back(mk(1, 32'h0,  0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 0,  1, 32'h11111111, 0,  0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h4,  0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 1,  1, 32'h22222222, 0,  0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h8,  0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 1,  1, 32'h33333333, 0,  0, 32'h0,        0));
        // IFU backpressure for 3 cycles: response held, no accept
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1, 32'h10, 0, 0,  0, 32'h0,  0, 32'h0,    4'h0, 1,
                              0, 1,  1, 32'h33333333, 0,  0, 32'h0,    0));
        end
        vecs.push_back(mk(1, 32'h10, 0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 1,  1, 32'hDEADBEEF, 0,  0, 32'h0,        0));
        // Continuous contention: LSU, IFU, LSU, IFU
        vecs.push_back(mk(1, 32'h0,  0, 1,  1, 32'h4,  1, 32'h0,        4'h0, 1,
                          0, 1,  0, 32'h0,        0,  1, 32'h22222222, 0));
        vecs.push_back(mk(1, 32'h0,  0, 1,  1, 32'h4,  1, 32'h0,        4'h0, 1,
                          1, 0,  1, 32'h11111111, 0,  0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h0,  0, 1,  1, 32'h4,  1, 32'h0,        4'h0, 1,
                          0, 1,  0, 32'h0,        0,  1, 32'h22222222, 0));
        vecs.push_back(mk(1, 32'h0,  0, 1,  1, 32'h4,  1, 32'h0,        4'h0, 1,
                          1, 0,  1, 32'h11111111, 0,  0, 32'h0,        0));
        // Byte-masked write then immediate fetch of the same word
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h20, 0, 32'h0000AB00, 4'h2, 1,
                          0, 1,  0, 32'h0,        0,  1, 32'h0,        0));
        vecs.push_back(mk(1, 32'h20, 0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 0,  1, 32'h1122AB44, 0,  0, 32'h0,        0));
        // Flush while a response is held, with a new fetch the same cycle
        vecs.push_back(mk(1, 32'h10, 0, 0,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          0, 1,  1, 32'h1122AB44, 0,  0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h40, 1, 0,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 1,  1, 32'h40404040, 0,  0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  1, 0,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 1,  0, 32'h0,        0,  0, 32'h0,        0));
        // Out-of-range accesses
        vecs.push_back(mk(1, OOR,    0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 1,  1, 32'h0,        1,  0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, OOR,    1, 32'h0,        4'h0, 1,
                          0, 1,  0, 32'h0,        0,  1, 32'h0,        1));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, OOR | 32'h10, 0, 32'hFFFFFFFF, 4'hF, 1,
                          1, 1,  0, 32'h0,        0,  1, 32'h0,        1));
        vecs.push_back(mk(1, 32'h10, 0, 1,  0, 32'h0,  0, 32'h0,        4'h0, 1,
                          1, 0,  1, 32'hDEADBEEF, 0,  0, 32'h0,        0));
        // LSU backpressure
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h8,  1, 32'h0,        4'h0, 0,
                          0, 1,  0, 32'h0,        0,  1, 32'h33333333, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1,  1, 32'h0,  1, 32'h0,        4'h0, 0,
                          1, 0,  0, 32'h0,        0,  1, 32'h33333333, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d ifu_cmd_ready", i), 32'(bus.ifu_cmd_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d lsu_cmd_ready", i), 32'(bus.lsu_cmd_ready), 32'(vecs[i].e_lr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ifu_rsp_valid", i), 32'(bus.ifu_rsp_valid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d lsu_rsp_valid", i), 32'(bus.lsu_rsp_valid), 32'(vecs[i].e_lv));
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d ifu_rsp_rdata", i), bus.ifu_rsp_rdata, vecs[i].e_id);
                chk($sformatf("v%0d ifu_rsp_err", i), 32'(bus.ifu_rsp_err), 32'(vecs[i].e_ie));
            end
            if (vecs[i].e_lv) begin
                chk($sformatf("v%0d lsu_rsp_rdata", i), bus.lsu_rsp_rdata, vecs[i].e_ld);
                chk($sformatf("v%0d lsu_rsp_err", i), 32'(bus.lsu_rsp_err), 32'(vecs[i].e_le));
            end
        end

        // Reset mid-transaction: held LSU response and pending commands are dropped
        bus.ifu_cmd_valid = 1'b1;
        bus.ifu_cmd_addr  = 32'h0;
        bus.ifu_flush     = 1'b0;
        bus.ifu_rsp_ready = 1'b1;
        bus.lsu_cmd_valid = 1'b1;
        bus.lsu_cmd_addr  = 32'h4;
        bus.lsu_cmd_read  = 1'b1;
        bus.lsu_rsp_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd0);
        chk("midreset lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd0);
        chk("midreset lsu_rsp_rdata", bus.lsu_rsp_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        // First contended grant after reset goes to LSU
        chk("post-reset lsu_cmd_ready", 32'(bus.lsu_cmd_ready), 32'd1);
        chk("post-reset ifu_cmd_ready", 32'(bus.ifu_cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd1);
        chk("post-reset lsu_rsp_rdata (array kept)", bus.lsu_rsp_rdata, 32'h22222222);
        chk("post-reset ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset 2nd ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd1);
        chk("post-reset 2nd ifu_rsp_rdata", bus.ifu_rsp_rdata, 32'h11111111);
        chk("post-reset 2nd lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/itcm_ctrl.md
Name: itcm_ctrl

Overview:
- Single-port instruction tightly-coupled memory (ITCM) controller.
- Responder end of the fetch interface: serves aligned 32-bit word reads to the IFU, plus read/write word accesses from the LSU (program load, self-modifying code, data in ITCM).
- Arbitrates both requesters onto one synchronous SRAM array. Each port has a one-entry response register with valid/ready backpressure.

Parameters:
- DEPTH_LOG2, 14, log2 of array depth in 32-bit words (default 64 KB).
- AW, 32, request address width.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ifu_cmd_valid  in  1  IFU fetch request valid.
- ifu_cmd_ready  out  1  fetch request accepted this cycle.
- ifu_cmd_addr  in  AW  fetch byte address; bits [1:0] ignored.
- ifu_flush  in  1  pipeline flush: discard any held IFU response.
- ifu_rsp_valid  out  1  fetch data valid.
- ifu_rsp_ready  in  1  IFU consumes the response.
- ifu_rsp_rdata  out  DW  fetched word.
- ifu_rsp_err  out  1  address out of range.
- lsu_cmd_valid  in  1  LSU request valid.
- lsu_cmd_ready  out  1  LSU request accepted.
- lsu_cmd_addr  in  AW  byte address; bits [1:0] ignored.
- lsu_cmd_read  in  1  1 = read, 0 = write.
- lsu_cmd_wdata  in  DW  write data.
- lsu_cmd_wmask  in  DW/8  byte write enables.
- lsu_rsp_valid  out  1  LSU response valid (reads and writes).
- lsu_rsp_ready  in  1  LSU consumes the response.
- lsu_rsp_rdata  out  DW  read data; 0 for writes.
- lsu_rsp_err  out  1  address out of range.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all rsp_valid=0, rsp_rdata=0, rsp_err=0, rr_last=0 (IFU).
  - The array is not cleared.
  - A reset mid-transaction drops any in-flight command and response.
- Addressing:
  - word index = addr[DEPTH_LOG2+1:2].
  - Range check: addr[AW-1:DEPTH_LOG2+2] is zero. A nonzero value is out of range: err=1, rdata=0, array not written.
- Slot availability: slot_free_x = ~x_rsp_valid | x_rsp_ready. This allows back-to-back streaming when the consumer is ready.
- Arbitration, one array access per cycle, combinational:
  - req_x = x_cmd_valid & slot_free_x.
  - If only one port requests, it is granted.
  - If both request, grant the port not equal to rr_last. rr_last updates to the granted port on every grant.
  - x_cmd_ready = grant_x. Ready may depend on the other port's valid, never on the port's own valid.
- Latency: a command accepted in cycle N is executed at the edge ending N. The response register loads at that edge, so x_rsp_valid=1 in N+1.
  - Read: rdata = array word.
  - Write: bytes with wmask=1 updated, rdata=0.
- Response hold: valid, rdata and err stay stable until the rsp_ready handshake.
  - Handshake with no new grant: valid clears.
  - Handshake with a simultaneous grant: the register reloads.
- Hazards: a read in N+1 of an address written in N returns the new data. Concurrent read and write are impossible under the single grant.
- Flush:
  - ifu_flush=1 clears ifu_rsp_valid at the next edge, dropping the held word.
  - An IFU command accepted in the same cycle as the flush is still served (post-flush PC) and its response appears in N+1.
  - During a flush cycle, slot_free_ifu is 1 regardless of ifu_rsp_ready.
  - Flush has no effect on the LSU port.
- Throughput: without contention, each port sustains 1 access/cycle. Under continuous contention, each port gets 1 access per 2 cycles.

Test Plan:
- Reset, then preload 0x10 via LSU writes (mask 1111) of 0xDEADBEEF → LSU response returns rdata=0, err=0. IFU fetch 0x10 → ifu_rsp_valid in the next cycle with rdata=0xDEADBEEF.
- IFU streams fetches 0x0, 0x4, 0x8 with rsp_ready=1 → one response per cycle, in order, latency 1. Hold ifu_rsp_ready=0 for 3 cycles → ifu_cmd_ready=0 and the response stays stable.
- Both ports valid every cycle → grants alternate LSU, IFU, LSU, …; first grant after reset goes to LSU.
- LSU write 0x20 with wmask=0010 and wdata=0x0000AB00 onto 0x11223344, then an IFU read of 0x20 the next cycle → 0x1122AB44.
- IFU response held (ready=0), assert ifu_flush with a new cmd at 0x40 → old response discarded, next response is mem[0x40].
- Addresses 1<<(DEPTH_LOG2+2) on both ports → err=1 and rdata=0. LSU write to the same address → array unchanged.
